// File: rtl/time_keeper.sv
// time_keeper: alarm-clock timekeeping core; run/set modes, field increments, alarm match and ring.
// CT/ST use the display packing: day, binary hour, BCD minute tens/units.
module time_keeper #(
    parameter int CLK_PER_SEC = 50000000
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [1:0]  S,
    input  logic [1:0]  CW,
    input  logic        Inc,
    input  logic        Ack,
    output logic [14:0] CT,
    output logic [15:0] ST,
    output logic [5:0]  Sec,
    output logic        Tick,
    output logic        Ring
);
    localparam int PW = $clog2(CLK_PER_SEC);
    localparam logic [PW-1:0] LAST = PW'(CLK_PER_SEC - 1);

    logic [PW-1:0] pcnt, pcnt_n;
    logic [5:0]    sec_n;
    logic [14:0]   ct_n;
    logic [15:0]   st_n;
    logic inc_q, ack_q, inc_e, ack_e, set_t, a_inc, wrap, min_wrap;
    logic t_min, t_hr, t_day, hit, ring_n;

    // BCD minute pair increment, 59 wraps to 00 with no carry out
    function automatic logic [6:0] min_inc(input logic [6:0] m);
        return m[3:0] == 4'd9 ? {m[6:4] == 3'd5 ? 3'd0 : m[6:4] + 3'd1, 4'd0}
                              : {m[6:4], m[3:0] + 4'd1};
    endfunction

    function automatic logic [4:0] hr_inc(input logic [4:0] h);
        return h == 5'd23 ? 5'd0 : h + 5'd1;
    endfunction

    always_comb begin
        inc_e    = Inc & ~inc_q;
        ack_e    = Ack & ~ack_q;
        set_t    = S == 2'b01;
        a_inc    = S == 2'b10 && inc_e;
        wrap     = !set_t && pcnt == LAST;
        min_wrap = wrap && Sec == 6'd59;
        pcnt_n   = (set_t || wrap) ? '0 : pcnt + PW'(1);
        sec_n    = set_t ? 6'd0 : !wrap ? Sec : Sec == 6'd59 ? 6'd0 : Sec + 6'd1;
        t_min    = min_wrap || (set_t && inc_e && CW == 2'b00);
        t_hr     = (min_wrap && CT[6:0] == 7'h59) || (set_t && inc_e && CW == 2'b01);
        t_day    = (min_wrap && CT[11:0] == {5'd23, 7'h59}) || (set_t && inc_e && CW == 2'b10);
        ct_n     = {t_day ? (CT[14:12] == 3'd6 ? 3'd0 : CT[14:12] + 3'd1) : CT[14:12],
                    t_hr ? hr_inc(CT[11:7]) : CT[11:7],
                    t_min ? min_inc(CT[6:0]) : CT[6:0]};
        // alarm day is 3 bits so +1 wraps 7 (daily) back to 0 naturally
        st_n     = {ST[15] ^ (a_inc && CW == 2'b11),
                    a_inc && CW == 2'b10 ? ST[14:12] + 3'd1 : ST[14:12],
                    a_inc && CW == 2'b01 ? hr_inc(ST[11:7]) : ST[11:7],
                    a_inc && CW == 2'b00 ? min_inc(ST[6:0]) : ST[6:0]};
        hit      = min_wrap && ST[15] && ct_n[11:0] == ST[11:0] &&
                   (ST[14:12] == 3'd7 || ST[14:12] == ct_n[14:12]);
        // clearing beats setting; a disabled alarm can never be left ringing
        ring_n   = (ack_e || !st_n[15]) ? 1'b0 : hit | Ring;
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            pcnt  <= '0;
            Sec   <= '0;
            CT    <= '0;
            ST    <= '0;
            Tick  <= 1'b0;
            Ring  <= 1'b0;
            inc_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            pcnt  <= pcnt_n;
            Sec   <= sec_n;
            CT    <= ct_n;
            ST    <= st_n;
            Tick  <= wrap;
            Ring  <= ring_n;
            inc_q <= Inc;
            ack_q <= Ack;
        end
    end
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: random and directed stimulus against a minutes-of-week reference model.
module tb_time_keeper;
    localparam int CPS = 4;

    logic        Clk = 1'b0;
    logic        Clr;
    logic [1:0]  S, CW;
    logic        Inc, Ack;
    logic [14:0] CT;
    logic [15:0] ST;
    logic [5:0]  Sec;
    logic        Tick, Ring;

    int total = 0, bad = 0, tick_cnt = 0;
    int m_tm, m_sec, m_pc, m_tick, m_ring, m_aen, m_aday, m_ahr, m_amin, m_incp, m_ackp;

    time_keeper #(.CLK_PER_SEC(CPS)) dut (
        .Clk(Clk), .Clr(Clr), .S(S), .CW(CW), .Inc(Inc), .Ack(Ack),
        .CT(CT), .ST(ST), .Sec(Sec), .Tick(Tick), .Ring(Ring)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] exp_ct();
        int d, h, mn;
        d  = m_tm / 1440;
        h  = (m_tm / 60) % 24;
        mn = m_tm % 60;
        return {3'(d), 5'(h), 3'(mn / 10), 4'(mn % 10)};
    endfunction

    function automatic logic [15:0] exp_st();
        return {1'(m_aen), 3'(m_aday), 5'(m_ahr), 3'(m_amin / 10), 4'(m_amin % 10)};
    endfunction

    task automatic m_reset();
        m_tm = 0; m_sec = 0; m_pc = 0; m_tick = 0; m_ring = 0;
        m_aen = 0; m_aday = 0; m_ahr = 0; m_amin = 0; m_incp = 0; m_ackp = 0;
    endtask

    task automatic m_step();
        int ie, ae, wr, hit, d, h, mn;
        ie = (Inc && !m_incp) ? 1 : 0;
        ae = (Ack && !m_ackp) ? 1 : 0;
        m_incp = Inc;
        m_ackp = Ack;
        wr = 0;
        if (S == 2'b01) begin
            m_pc = 0; m_sec = 0; m_tick = 0;
            if (ie == 1) begin
                d = m_tm / 1440; h = (m_tm / 60) % 24; mn = m_tm % 60;
                if (CW == 2'b00) mn = (mn + 1) % 60;
                if (CW == 2'b01) h = (h + 1) % 24;
                if (CW == 2'b10) d = (d + 1) % 7;
                m_tm = d * 1440 + h * 60 + mn;
            end
        end else if (m_pc == CPS - 1) begin
            m_pc = 0; m_tick = 1;
            m_sec++;
            if (m_sec == 60) begin
                m_sec = 0; wr = 1;
                m_tm = (m_tm + 1) % 10080;
            end
        end else begin
            m_pc++; m_tick = 0;
        end
        hit = (wr == 1 && m_aen == 1 && m_ahr * 60 + m_amin == m_tm % 1440 &&
               (m_aday == 7 || m_aday == m_tm / 1440)) ? 1 : 0;
        if (S == 2'b10 && ie == 1) begin
            if (CW == 2'b00) m_amin = (m_amin + 1) % 60;
            if (CW == 2'b01) m_ahr = (m_ahr + 1) % 24;
            if (CW == 2'b10) m_aday = (m_aday + 1) % 8;
            if (CW == 2'b11) m_aen = 1 - m_aen;
        end
        m_ring = (ae == 1 || m_aen == 0) ? 0 : (hit == 1 ? 1 : m_ring);
    endtask

    task automatic check_all();
        chk("ct", 32'(CT), 32'(exp_ct()));
        chk("st", 32'(ST), 32'(exp_st()));
        chk("sec", 32'(Sec), 32'(m_sec));
        chk("tick", 32'(Tick), 32'(m_tick));
        chk("ring", 32'(Ring), 32'(m_ring));
    endtask

    task automatic step();
        @(posedge Clk);
        m_step();
        #1;
        check_all();
        tick_cnt += int'(Tick);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input logic [1:0] cw);
        CW = cw; Inc = 1'b1; step();
        Inc = 1'b0; step();
    endtask

    task automatic rst_async();
        #2 Clr = 1'b0;
        #1 m_reset();
        check_all();
        @(posedge Clk);
        #1 Clr = 1'b1;
    endtask

    task automatic set_time(input int d, input int h, input int mn);
        int nm, nh, nd;
        S = 2'b01;
        nm = (mn - m_tm % 60 + 60) % 60;
        nh = (h - (m_tm / 60) % 24 + 24) % 24;
        nd = (d - m_tm / 1440 + 7) % 7;
        for (int i = 0; i < nm; i++) press(2'b00);
        for (int i = 0; i < nh; i++) press(2'b01);
        for (int i = 0; i < nd; i++) press(2'b10);
    endtask

    task automatic set_alarm(input int en, input int d, input int h, input int mn);
        int nm, nh, nd;
        S = 2'b10;
        nm = (mn - m_amin + 60) % 60;
        nh = (h - m_ahr + 24) % 24;
        nd = (d - m_aday + 8) % 8;
        for (int i = 0; i < nm; i++) press(2'b00);
        for (int i = 0; i < nh; i++) press(2'b01);
        for (int i = 0; i < nd; i++) press(2'b10);
        if (m_aen != en) press(2'b11);
    endtask

    initial begin
        Clr = 1'b1; S = 2'b00; CW = 2'b00; Inc = 1'b0; Ack = 1'b0;
        m_reset();
        #1 rst_async();
        cyc(3);
        chk("first_tick_early", 32'(Tick), 0);
        step();
        chk("first_tick", 32'(Tick), 1);

        // mid-count asynchronous reset from 20:53:17 day 0
        set_time(0, 20, 53);
        S = 2'b00;
        cyc(17 * CPS + 2);
        chk("pre_rst_ct", 32'(CT), 32'h0A53);
        chk("pre_rst_sec", 32'(Sec), 17);
        rst_async();
        chk("rst_ct", 32'(CT), 0);
        chk("rst_sec", 32'(Sec), 0);
        cyc(CPS - 1);
        chk("rst_tick_early", 32'(Tick), 0);
        step();
        chk("rst_tick", 32'(Tick), 1);

        // week rollover
        set_time(6, 23, 59);
        S = 2'b00;
        tick_cnt = 0;
        cyc(60 * CPS);
        chk("roll_ct", 32'(CT), 0);
        chk("roll_sec", 32'(Sec), 0);
        chk("roll_ticks", 32'(tick_cnt), 60);

        // set-time minute wrap and held Inc
        set_time(3, 5, 59);
        press(2'b00);
        chk("wrap_min", 32'(CT[6:0]), 0);
        chk("wrap_hr", 32'(CT[11:7]), 5);
        Inc = 1'b1;
        cyc(10);
        Inc = 1'b0;
        step();
        chk("held_inc", 32'(CT[6:0]), 1);
        chk("set_sec", 32'(Sec), 0);

        // alarm day field through daily and back
        S = 2'b10;
        for (int i = 0; i < 7; i++) press(2'b10);
        chk("aday7", 32'(ST[14:12]), 7);
        press(2'b10);
        chk("aday0", 32'(ST[14:12]), 0);
        press(2'b11);
        chk("aen", 32'(ST[15]), 1);

        // ring on daily match
        set_alarm(1, 7, 7, 30);
        chk("alarm_word", 32'(ST), 32'hF3B0);
        set_time(2, 7, 29);
        S = 2'b00;
        cyc(59 * CPS);
        chk("pre_ring_sec", 32'(Sec), 59);
        chk("pre_ring", 32'(Ring), 0);
        cyc(CPS);
        chk("ring_ct", 32'(CT), 32'h23B0);
        chk("ring_set", 32'(Ring), 1);
        Ack = 1'b1;
        step();
        chk("ack_clr", 32'(Ring), 0);
        set_time(2, 7, 29);
        S = 2'b00;
        cyc(60 * CPS);
        chk("ack_held_ring", 32'(Ring), 1);
        Ack = 1'b0; step();
        Ack = 1'b1; step();
        Ack = 1'b0; step();
        chk("ack_clr2", 32'(Ring), 0);

        // set coincident with ack edge
        set_time(2, 7, 29);
        S = 2'b00;
        cyc(60 * CPS - 1);
        Ack = 1'b1;
        step();
        chk("coinc_ct", 32'(CT), 32'h23B0);
        chk("coinc_ring", 32'(Ring), 0);
        Ack = 1'b0;

        // disable while ringing
        set_time(2, 7, 29);
        S = 2'b00;
        cyc(60 * CPS);
        chk("ring_again", 32'(Ring), 1);
        S = 2'b10; CW = 2'b11; Inc = 1'b1;
        step();
        chk("dis_en", 32'(ST[15]), 0);
        chk("dis_ring", 32'(Ring), 0);
        Inc = 1'b0;
        step();

        // time edit onto the alarm never rings
        press(2'b11);
        set_time(2, 7, 29);
        press(2'b00);
        chk("edit_ct", 32'(CT), 32'h23B0);
        cyc(3);
        chk("edit_ring", 32'(Ring), 0);

        // random traffic, alarm armed a minute ahead
        set_alarm(1, 7, 7, 31);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) S = 2'($urandom_range(0, 3));
            CW  = 2'($urandom_range(0, 3));
            Inc = $urandom_range(0, 3) == 0;
            Ack = $urandom_range(0, 7) == 0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
